// File: rtl/routing_target_resp.sv
// Return-route lookup for a routing target: queues initiator IDs from request headers
// and turns each response into a registered return route. Optional macro: ROUTING_TARGET_ERRCNT_EN.
module routing_target_resp #(
    parameter int DEPTH = 4
) (
    input  logic       clock_i,
    input  logic       reset_n_i,
    input  logic       req_valid_i,
    output logic       req_ready_o,
    input  logic [3:0] req_source_i,
    input  logic       resp_valid_i,
    output logic       resp_ready_o,
    output logic       rt_valid_o,
    input  logic       rt_ready_i,
    output logic [6:0] rt_path_o,
    output logic [3:0] rt_dest_o,
    output logic       failed_decoding_o,
    output logic [7:0] err_count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [3:0]    id_mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          rt_valid_q, rt_valid_d;
    logic [6:0]    rt_path_q, rt_path_d;
    logic [3:0]    rt_dest_q, rt_dest_d;
    logic          failed_q, failed_d;
    logic          push, pop;
    logic [3:0]    head_id;
    logic [7:0]    head_route;

    // Bit 7 flags an ID with no return-route entry; bits 6:0 are the path.
    function automatic logic [7:0] lookup_route(input logic [3:0] id);
        case (id)
            4'h3:    lookup_route = {1'b0, 7'b0000001};
            4'h4:    lookup_route = {1'b0, 7'b0000010};
            4'h9:    lookup_route = {1'b0, 7'b0001001};
            default: lookup_route = {1'b1, 7'b0000000};
        endcase
    endfunction

    assign req_ready_o  = (count_q < CW'(DEPTH));
    assign resp_ready_o = (count_q != '0) && (!rt_valid_q || rt_ready_i);
    assign push         = req_valid_i && req_ready_o;
    assign pop          = resp_valid_i && resp_ready_o;
    assign head_id      = id_mem[rd_ptr_q];
    assign head_route   = lookup_route(head_id);

    // Entry storage carries no reset: count gates every read of it.
    always_ff @(posedge clock_i) begin
        if (push) begin
            id_mem[wr_ptr_q] <= req_source_i;
        end
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        rt_valid_d = rt_valid_q;
        rt_path_d  = rt_path_q;
        rt_dest_d  = rt_dest_q;
        failed_d   = failed_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        if (pop) begin
            rt_valid_d = 1'b1;
            rt_path_d  = head_route[6:0];
            rt_dest_d  = head_id;
            failed_d   = head_route[7];
        end else if (rt_ready_i) begin
            rt_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rt_valid_q <= 1'b0;
            rt_path_q  <= '0;
            rt_dest_q  <= '0;
            failed_q   <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            rt_valid_q <= rt_valid_d;
            rt_path_q  <= rt_path_d;
            rt_dest_q  <= rt_dest_d;
            failed_q   <= failed_d;
        end
    end

`ifdef ROUTING_TARGET_ERRCNT_EN
    logic [7:0] err_q, err_d;

    always_comb begin
        err_d = err_q;
        if (pop && head_route[7] && (err_q != 8'hFF)) begin
            err_d = err_q + 8'd1;
        end
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            err_q <= 8'h00;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_count_o = err_q;
`else
    assign err_count_o = 8'h00;
`endif

    assign rt_valid_o        = rt_valid_q;
    assign rt_path_o         = rt_path_q;
    assign rt_dest_o         = rt_dest_q;
    assign failed_decoding_o = failed_q;
endmodule

// File: doc/routing_target_resp.md
ROUTING_TARGET_RESP -- requirements
Module: routing_target_resp

Interface
REQ-001 Parameter DEPTH, default 4, outstanding-request tracking depth; power of two, 2..16.
REQ-002 clock  input  1  single clock; all state updates on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 req_valid  input  1  request header accepted from the network side.
REQ-005 req_ready  output  1  block can record another outstanding request.
REQ-006 req_source  input  4  initiator ID carried in the request header.
REQ-007 resp_valid  input  1  target core presents a response needing a return route.
REQ-008 resp_ready  output  1  route lookup accepts the response this cycle.
REQ-009 rt_valid  output  1  registered return route valid.
REQ-010 rt_ready  input  1  downstream packetizer consumes the route.
REQ-011 rt_path  output  7  return path, first hop in LSBs, last hop in MSBs.
REQ-012 rt_dest  output  4  initiator ID the response returns to.
REQ-013 failed_decoding  output  1  rt_source has no return-route entry; qualified by rt_valid.
REQ-014 err_count  output  8  failed-decode counter (see Configuration).

Function
REQ-015 Block SHALL hold a FIFO of DEPTH initiator IDs; occupancy count width clog2(DEPTH)+1; read/write pointers wrap modulo DEPTH.
REQ-016 req_ready SHALL be combinational: high iff count < DEPTH; push occurs iff req_valid && req_ready, storing req_source.
REQ-017 resp_ready SHALL be combinational: high iff count != 0 and (!rt_valid || rt_ready).
REQ-018 Pop occurs iff resp_valid && resp_ready; no same-cycle bypass: an ID pushed in cycle N is poppable from cycle N+1.
REQ-019 Simultaneous push and pop SHALL leave count unchanged; at full, push is blocked by req_ready even if a pop occurs that cycle.
REQ-020 On pop, next cycle SHALL show rt_valid=1, rt_dest=head ID, rt_path=table(head ID), failed_decoding per REQ-021 (latency 1 cycle).
REQ-021 Return-route table: 4'h3 -> 7'b0000001; 4'h4 -> 7'b0000010; 4'h9 -> 7'b0001001; any other ID -> rt_path=0, failed_decoding=1.
REQ-022 rt_valid, rt_path, rt_dest, failed_decoding SHALL hold stable while rt_valid && !rt_ready.
REQ-023 rt_valid SHALL clear after rt_ready handshake unless a new pop occurs the same cycle, in which case the new route loads.
REQ-024 A failed decode SHALL still pop its entry and emit rt_valid (response drained, flagged as error).

Reset
REQ-025 While reset_n=0: count=0, pointers=0, req_ready=1, resp_ready=0, rt_valid=0, rt_path=0, rt_dest=0, failed_decoding=0, err_count=0.
REQ-026 Reset asserted mid-operation SHALL discard all outstanding entries and any held route immediately, without waiting for a clock edge.

Configuration
REQ-027 Macro ROUTING_TARGET_ERRCNT_EN defined: err_count increments by 1 on each pop producing failed_decoding=1, saturating at 8'hFF.
REQ-028 Macro ROUTING_TARGET_ERRCNT_EN undefined: err_count tied to 8'h00, no counter logic; all other behaviour identical.

Verification
REQ-029 Push IDs 3,4,9 then pop three times with rt_ready=1 -> routes 7'b0000001, 7'b0000010, 7'b0001001 in order, failed_decoding=0, one cycle after each pop.
REQ-030 Push 4 entries (DEPTH=4) -> req_ready=0; pop and push same cycle -> push refused, count=3, next cycle req_ready=1.
REQ-031 Push ID 5, pop -> rt_valid=1, rt_path=0, rt_dest=4'h5, failed_decoding=1; with macro err_count=1, without err_count=0.
REQ-032 Hold rt_ready=0 with two entries queued -> first route held stable, resp_ready=0, second pop only after rt_ready handshake.
REQ-033 Drop reset_n mid-stream with 3 entries and rt_valid=1 -> all outputs at reset values asynchronously; after release, pop of stale entries impossible (resp_ready=0).
REQ-034 With macro, 256 failed decodes -> err_count saturates at 8'hFF.
